// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath and its output stage.
package conv_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_KERNEL_SIZE = 8;

    function automatic int result_width(input int dw, input int ks);
        return 2 * dw + $clog2(ks);
    endfunction

endpackage

// File: rtl/conv_requant_if.sv
// Streaming handshake between the convolution core, the requant stage and its consumer.
interface conv_requant_if
    import conv_pkg::*;
#(
    parameter int IN_WIDTH  = result_width(DEF_DATA_WIDTH, DEF_KERNEL_SIZE),
    parameter int OUT_WIDTH = 8
);
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_vld;
    logic                 in_last;
    logic                 in_rdy;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_vld;
    logic                 out_last;
    logic                 out_rdy;

    modport master (
        output in_data, in_vld, in_last,
        input  in_rdy,
        input  out_data, out_vld, out_last,
        output out_rdy
    );

    modport slave (
        input  in_data, in_vld, in_last,
        output in_rdy,
        output out_data, out_vld, out_last,
        input  out_rdy
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head entry is visible whenever empty is low.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr = wr_en & ~full;
    assign w_rd = rd_en & ~empty;

    // Pointers wrap on their own; the extra count bit separates full from empty.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = (r_count == (AW+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
endmodule

// File: rtl/conv_requant.sv
// Requantises the wide convolution sum (round-half-up, shift, saturate) into a credit-
// controlled output FIFO, and keeps overflow / saturation statistics.
module conv_requant
    import conv_pkg::*;
#(
    parameter int IN_WIDTH   = result_width(DEF_DATA_WIDTH, DEF_KERNEL_SIZE),
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SATCNT_W   = 16
) (
    input  logic                clk,
    input  logic                arst,
    conv_requant_if.slave       bus,
    input  logic                clear,
    output logic                overflow_err,
    output logic [SATCNT_W-1:0] sat_count,
    output logic                frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [IN_WIDTH:0] RND = ((IN_WIDTH+1)'(1) << SHIFT) >> 1;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic                 last;
    } fifo_entry_t;

    fifo_entry_t         r_s1_entry;
    fifo_entry_t         w_s1_next;
    fifo_entry_t         w_head;
    logic                r_s1_vld;
    logic                r_overflow;
    logic                r_frame_done;
    logic [SATCNT_W-1:0] r_sat_count;
    logic [IN_WIDTH:0]   w_rounded;
    logic [IN_WIDTH:0]   w_q;
    logic                w_sat;
    logic                w_in_rdy;
    logic                w_accept;
    logic                w_rd;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [AW:0]         w_fifo_count;
    logic [AW+1:0]       w_used;

    // One extra bit keeps the rounding carry before the shift.
    assign w_rounded = {1'b0, bus.in_data} + RND;
    assign w_q       = w_rounded >> SHIFT;
    assign w_sat     = (w_q >> OUT_WIDTH) != '0;

    always_comb begin
        w_s1_next      = '0;
        w_s1_next.data = w_sat ? {OUT_WIDTH{1'b1}} : w_q[OUT_WIDTH-1:0];
        w_s1_next.last = bus.in_last;
    end

    // Credits count the stage-1 slot as occupied, so a write never meets a full FIFO.
    assign w_used   = {1'b0, w_fifo_count} + (AW+2)'(r_s1_vld);
    assign w_in_rdy = ~arst & ~w_fifo_full & (w_used < (AW+2)'(FIFO_DEPTH));
    assign w_accept = bus.in_vld & w_in_rdy;
    assign w_rd     = ~w_fifo_empty & bus.out_rdy;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_s1_vld   <= 1'b0;
            r_s1_entry <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_entry <= w_s1_next;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .arst    (arst),
        .wr_en   (r_s1_vld),
        .wr_data (r_s1_entry),
        .rd_en   (w_rd),
        .rd_data (w_head),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

    // clear has priority over a same-cycle set or increment.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_overflow   <= 1'b0;
            r_sat_count  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_rd & w_head.last;
            if (clear) begin
                r_overflow  <= 1'b0;
                r_sat_count <= '0;
            end else begin
                if (bus.in_vld & ~w_in_rdy) begin
                    r_overflow <= 1'b1;
                end
                if (w_accept & w_sat & (r_sat_count != {SATCNT_W{1'b1}})) begin
                    r_sat_count <= r_sat_count + SATCNT_W'(1);
                end
            end
        end
    end

    assign bus.in_rdy   = w_in_rdy;
    assign bus.out_vld  = ~w_fifo_empty;
    assign bus.out_data = w_head.data;
    assign bus.out_last = w_head.last;
    assign overflow_err = r_overflow;
    assign sat_count    = r_sat_count;
    assign frame_done   = r_frame_done;
endmodule

// File: tb/tb_conv_requant.sv
// Directed and model-based checks of conv_requant with IN=19, OUT=8, SHIFT=8, depth 4.
module tb_conv_requant;
    localparam int IW    = 19;
    localparam int OW    = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        arst;
    logic        clear;
    logic        overflow_err;
    logic        frame_done;
    logic [15:0] sat_count;

    conv_requant_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    conv_requant #(
        .IN_WIDTH   (IW),
        .OUT_WIDTH  (OW),
        .SHIFT      (8),
        .FIFO_DEPTH (DEPTH),
        .SATCNT_W   (16)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .bus          (bus),
        .clear        (clear),
        .overflow_err (overflow_err),
        .sat_count    (sat_count),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] din;
        logic        last;
        logic [7:0]  exp;
        logic        sat;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    vec_t vecs[9];
    exp_t q[$];
    exp_t e;

    int checks   = 0;
    int failures = 0;
    int k, n, beats, sent, occ, exp_sat, nsat;
    logic acc, rd, fd_exp, have_head;
    logic [7:0]  head;
    logic [18:0] din;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-half-up at bit 7, drop 8 bits, clamp at 255.
    function automatic logic [7:0] model_q(input logic [18:0] d);
        logic [19:0] r;
        r = {1'b0, d} + 20'd128;
        if (r[19:8] > 12'd255) return 8'hFF;
        return r[15:8];
    endfunction

    function automatic logic model_sat(input logic [18:0] d);
        logic [19:0] r;
        r = {1'b0, d} + 20'd128;
        return r[19:8] > 12'd255;
    endfunction

    initial begin
        vecs[0] = '{19'h00000, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{19'h0007F, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{19'h00080, 1'b0, 8'h01, 1'b0};
        vecs[3] = '{19'h12345, 1'b0, 8'hFF, 1'b1};
        vecs[4] = '{19'h0FF7F, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{19'h0FF80, 1'b0, 8'hFF, 1'b1};
        vecs[6] = '{19'h7FFFF, 1'b0, 8'hFF, 1'b1};
        vecs[7] = '{19'h00180, 1'b1, 8'h02, 1'b0};
        vecs[8] = '{19'h0017F, 1'b0, 8'h01, 1'b0};

        arst = 1'b1; clear = 1'b0;
        bus.in_vld = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_vld", bus.out_vld, 0);
        chk("rst_in_rdy", bus.in_rdy, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_overflow", overflow_err, 0);
        chk("rst_frame_done", frame_done, 0);
        arst = 1'b0;
        tick();
        chk("rel_in_rdy", bus.in_rdy, 1);

        // Table: one isolated sample at a time, latency and frame_done per vector.
        bus.out_rdy = 1'b1;
        exp_sat = 0;
        for (int i = 0; i < 9; i++) begin
            bus.in_vld = 1'b1; bus.in_data = vecs[i].din; bus.in_last = vecs[i].last;
            chk($sformatf("tbl%0d_in_rdy", i), bus.in_rdy, 1);
            tick();
            bus.in_vld = 1'b0; bus.in_last = 1'b0;
            chk($sformatf("tbl%0d_lat1_vld", i), bus.out_vld, 0);
            tick();
            chk($sformatf("tbl%0d_vld", i), bus.out_vld, 1);
            chk($sformatf("tbl%0d_data", i), bus.out_data, vecs[i].exp);
            chk($sformatf("tbl%0d_last", i), bus.out_last, vecs[i].last);
            tick();
            chk($sformatf("tbl%0d_drained", i), bus.out_vld, 0);
            chk($sformatf("tbl%0d_frame_done", i), frame_done, vecs[i].last);
            if (vecs[i].sat) exp_sat++;
        end
        chk("tbl_sat_count", sat_count, exp_sat);

        // Five-sample frame back to back; in_last held high on idle cycles must be ignored.
        beats = 0; sent = 0;
        for (int c = 0; c < 20; c++) begin
            if (sent < 5) begin
                bus.in_vld = 1'b1; bus.in_data = 19'((sent + 1) * 256); bus.in_last = (sent == 4);
            end else begin
                bus.in_vld = 1'b0; bus.in_last = 1'b1;
            end
            acc = bus.in_vld & bus.in_rdy;
            rd  = bus.out_vld & bus.out_rdy;
            fd_exp = 1'b0;
            if (rd) begin
                beats++;
                chk("frm_data", bus.out_data, beats);
                chk("frm_last", bus.out_last, beats == 5);
                fd_exp = (beats == 5);
            end
            tick();
            if (acc) sent++;
            chk("frm_frame_done", frame_done, fd_exp);
        end
        chk("frm_beats", beats, 5);
        bus.in_vld = 1'b0; bus.in_last = 1'b0;

        // Backpressure: four credits, then stall; head must not move.
        bus.out_rdy = 1'b0; k = 0; have_head = 1'b0; head = '0;
        for (int c = 0; c < 8; c++) begin
            bus.in_vld = 1'b1; bus.in_data = 19'((k + 1) * 256);
            if (c == 4) chk("bp_in_rdy_fall", bus.in_rdy, 0);
            acc = bus.in_rdy;
            tick();
            if (acc) k++;
            if (bus.out_vld) begin
                if (!have_head) begin
                    head = bus.out_data; have_head = 1'b1;
                    chk("bp_first_head", head, 1);
                end else begin
                    chk("bp_head_stable", bus.out_data, head);
                end
            end
        end
        chk("bp_accepts", k, 4);
        chk("bp_overflow", overflow_err, 1);
        bus.in_vld = 1'b0; bus.out_rdy = 1'b1; n = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_vld) begin
                n++;
                chk("bp_drain_data", bus.out_data, n);
            end
            tick();
        end
        chk("bp_drain_count", n, 4);

        // clear collides with a saturating accept: statistics cleared, data kept.
        chk("clr_pre_overflow", overflow_err, 1);
        bus.in_vld = 1'b1; bus.in_data = 19'h7FFFF; clear = 1'b1;
        chk("clr_in_rdy", bus.in_rdy, 1);
        tick();
        bus.in_vld = 1'b0; clear = 1'b0;
        chk("clr_sat_count", sat_count, 0);
        chk("clr_overflow", overflow_err, 0);
        tick();
        chk("clr_data_vld", bus.out_vld, 1);
        chk("clr_data", bus.out_data, 8'hFF);
        tick();

        // Full rate input against random consumer stalls, compared with a queue model.
        nsat = 0; sent = 0; occ = 0; q.delete();
        for (int c = 0; c < 6000 && (sent < 1000 || q.size() > 0); c++) begin
            if (sent < 1000) begin
                din = 19'($urandom_range(0, 32'h7FFFF));
                bus.in_vld = 1'b1; bus.in_data = din; bus.in_last = ($urandom_range(0, 7) == 0);
            end else begin
                bus.in_vld = 1'b0; bus.in_last = 1'b0;
            end
            bus.out_rdy = ($urandom_range(0, 1) == 1);
            chk("rnd_credit", bus.in_rdy, occ < DEPTH);
            acc = bus.in_vld & bus.in_rdy;
            rd  = bus.out_vld & bus.out_rdy;
            fd_exp = 1'b0;
            if (rd) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious_vld", bus.out_vld, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_data", bus.out_data, e.d);
                    chk("rnd_last", bus.out_last, e.l);
                    fd_exp = e.l;
                end
            end
            if (acc) begin
                q.push_back('{model_q(din), bus.in_last});
                if (model_sat(din)) nsat++;
                sent++;
            end
            tick();
            occ = occ + int'(acc) - int'(rd);
            chk("rnd_frame_done", frame_done, fd_exp);
        end
        bus.in_vld = 1'b0; bus.in_last = 1'b0;
        chk("rnd_sent", sent, 1000);
        chk("rnd_queue_empty", q.size(), 0);
        chk("rnd_sat_count", sat_count, nsat);

        // Saturation counter ceiling.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("satc_cleared", sat_count, 0);
        n = 0; bus.out_rdy = 1'b1; bus.in_data = 19'h7FFFF; bus.in_last = 1'b0;
        for (int c = 0; c < 70000 && n < 65540; c++) begin
            bus.in_vld = 1'b1;
            acc = bus.in_rdy;
            tick();
            if (acc) begin
                n++;
                if (n == 65534) chk("satc_near_top", sat_count, 16'hFFFE);
            end
        end
        bus.in_vld = 1'b0;
        chk("satc_accepts", n, 65540);
        chk("satc_hold", sat_count, 16'hFFFF);
        repeat (4) tick();

        // Reset with three entries queued.
        bus.out_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.in_vld = 1'b1; bus.in_data = 19'((c + 5) * 256);
            chk("arst_fill_rdy", bus.in_rdy, 1);
            tick();
        end
        bus.in_vld = 1'b0;
        repeat (2) tick();
        chk("arst_pre_vld", bus.out_vld, 1);
        arst = 1'b1;
        #1;
        chk("arst_out_vld", bus.out_vld, 0);
        chk("arst_in_rdy", bus.in_rdy, 0);
        chk("arst_out_data", bus.out_data, 0);
        chk("arst_sat_count", sat_count, 0);
        tick();
        chk("arst_hold_in_rdy", bus.in_rdy, 0);
        chk("arst_hold_out_vld", bus.out_vld, 0);
        arst = 1'b0; bus.out_rdy = 1'b1;
        tick();
        chk("arst_rel_in_rdy", bus.in_rdy, 1);
        for (int c = 0; c < 4; c++) begin
            chk("arst_no_stale", bus.out_vld, 0);
            tick();
        end
        chk("arst_sat_zero", sat_count, 0);
        chk("arst_ovf_zero", overflow_err, 0);
        chk("arst_fd_zero", frame_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
